fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the synchronous instruction memory.
- Owns the PC and drives the memory address. The memory reads with a fixed 1-cycle latency and has no enable or stall, so the block tracks the in-flight read and captures returned words in a small response FIFO.
- Presents instructions to decode through a valid/ready handshake.
- Supports a run enable and a single-cycle redirect (branch/jump) that flushes all fetched and in-flight words.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_resp_fifo.sv | 64 ++++++
 rtl/fetch_ctrl.sv | 86 ++++++++
 tb/tb_fetch_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and the response-FIFO payload for the instruction fetch path.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_resp_fifo.sv
// Small synchronous FIFO holding fetched (pc, instr) pairs; flush empties it in one edge.
module fetch_resp_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  fetch_entry_t     mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Issue throttling upstream guarantees a free slot for every returning word.
  always_ff @(posedge clk) begin
    if (rst_n && push && !pop && !flush) begin
      assert (count_q < CNT_W'(DEPTH));
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks the one in-flight memory read, and
// queues returned words for decode behind a valid/ready handshake.
module fetch_ctrl #(
  parameter int unsigned        ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned        INSTR_W  = fetch_pkg::INSTR_W,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = fetch_pkg::DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy
);

  import fetch_pkg::*;

  localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
  localparam int unsigned       OCC_W      = CNT_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ;

  // Occupancy after this edge must leave room for the word a new issue will return.
  always_comb begin
    pop              = out_valid & out_ready;
    push             = inflight_q & ~redirect_valid;
    occ              = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue            = run & ~redirect_valid & (occ < OCC_W'(DEPTH));
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC & ALIGN_MASK;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc & ALIGN_MASK;
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + ADDR_W'(PC_STEP);
      inflight_pc_q <= pc_q;
      inflight_q    <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign mem_addr  = pc_q;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign busy      = inflight_q | out_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, backpressure, redirect, run gating, PC wrap, async reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b1;
  logic        out_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic [31:0] mem_addr, mem_data, out_instr, out_pc;
  logic        out_valid, busy;

  logic [31:0] w_mem_addr, w_mem_data, w_out_instr, w_out_pc;
  logic        w_out_valid, w_busy;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 1-cycle synchronous instruction memory, one read port per DUT.
  always @(posedge clk) begin
    mem_data   <= mem[mem_addr[5:2]];
    w_mem_data <= mem[w_mem_addr[5:2]];
  end

  fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem_addr(mem_addr), .mem_data(mem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .busy(busy)
  );

  fetch_ctrl #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(1'b1), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, instr);
  endtask

  task automatic chk_whead(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(w_out_valid), 32'd1);
    chk({tag, "_pc"}, w_out_pc, pc);
    chk({tag, "_instr"}, w_out_instr, instr);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    mem[0] = 32'hA000_00AA;
    mem[1] = 32'h1000_0011;
    mem[2] = 32'h2000_0022;
    mem[3] = 32'h3000_0033;
    for (int i = 4; i < 16; i++) mem[i] = 32'hC000_0000 | 32'(i);

    // Reset state
    step();
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_waddr", w_mem_addr, 32'hFFFF_FFF8);

    // Streaming
    rst_n = 1'b1;
    #1;
    chk("s0_addr", mem_addr, 32'h0);
    chk("s0_valid", 32'(out_valid), 32'd0);
    step();
    chk("s1_addr", mem_addr, 32'h4);
    chk("s1_valid", 32'(out_valid), 32'd0);
    step();
    chk("s2_addr", mem_addr, 32'h8);
    chk_head("s2", 32'h0, 32'hA000_00AA);
    chk_whead("w2", 32'hFFFF_FFF8, 32'hC000_000E);
    step();
    chk("s3_addr", mem_addr, 32'hC);
    chk_head("s3", 32'h4, 32'h1000_0011);
    chk_whead("w3", 32'hFFFF_FFFC, 32'hC000_000F);
    step();
    chk("s4_addr", mem_addr, 32'h10);
    chk_head("s4", 32'h8, 32'h2000_0022);
    chk_whead("w4", 32'h0, 32'hA000_00AA);
    chk("w4_busy", 32'(w_busy), 32'd1);

    // Restart at 0 (low bits ignored) under backpressure
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1;
    out_ready      = 1'b0;
    step();
    redirect_valid = 1'b0;
    chk("bp1_valid", 32'(out_valid), 32'd0);
    chk("bp1_addr", mem_addr, 32'h0);
    step();
    chk("bp2_valid", 32'(out_valid), 32'd0);
    chk("bp2_addr", mem_addr, 32'h4);
    step();
    chk_head("bp3", 32'h0, 32'hA000_00AA);
    chk("bp3_addr", mem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_head("bp_hold", 32'h0, 32'hA000_00AA);
      chk("bp_hold_addr", mem_addr, 32'h8);
      chk("bp_hold_busy", 32'(busy), 32'd1);
    end

    // Release: no loss, no duplication
    out_ready = 1'b1;
    step();
    chk_head("rel1", 32'h4, 32'h1000_0011);
    step();
    chk_head("rel2", 32'h8, 32'h2000_0022);
    step();
    chk_head("rel3", 32'hC, 32'h3000_0033);
    out_ready = 1'b0;
    step();
    chk_head("full", 32'hC, 32'h3000_0033);
    chk("full_addr", mem_addr, 32'h14);

    // Redirect while full
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_000E;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("rd1_valid", 32'(out_valid), 32'd0);
    chk("rd1_addr", mem_addr, 32'hC);
    chk("rd1_busy", 32'(busy), 32'd0);
    step();
    chk("rd2_valid", 32'(out_valid), 32'd0);
    chk("rd2_addr", mem_addr, 32'h10);
    step();
    chk_head("rd3", 32'hC, 32'h3000_0033);
    chk("rd3_addr", mem_addr, 32'h14);
    step();
    chk_head("rd4", 32'h10, 32'hC000_0004);
    step();
    chk_head("rd5", 32'h14, 32'hC000_0005);

    // Run gating
    run = 1'b0;
    step();
    chk_head("rg1", 32'h18, 32'hC000_0006);
    chk("rg1_addr", mem_addr, 32'h1C);
    chk("rg1_busy", 32'(busy), 32'd1);
    step();
    chk("rg2_valid", 32'(out_valid), 32'd0);
    chk("rg2_busy", 32'(busy), 32'd0);
    chk("rg2_addr", mem_addr, 32'h1C);
    step();
    chk("rg3_busy", 32'(busy), 32'd0);
    chk("rg3_addr", mem_addr, 32'h1C);
    run = 1'b1;
    step();
    chk("rg4_valid", 32'(out_valid), 32'd0);
    chk("rg4_addr", mem_addr, 32'h20);
    step();
    chk_head("rg5", 32'h1C, 32'hC000_0007);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_addr", mem_addr, 32'h0);
    chk("ar_waddr", w_mem_addr, 32'hFFFF_FFF8);
    step();
    rst_n = 1'b1;
    #1;
    chk("ar0_addr", mem_addr, 32'h0);
    step();
    chk("ar1_addr", mem_addr, 32'h4);
    chk("ar1_valid", 32'(out_valid), 32'd0);
    step();
    chk_head("ar2", 32'h0, 32'hA000_00AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
